// File: rtl/uart_host_streamer_if.sv
// Native register bus between the host streamer (master) and the tester UART (slave).
interface uart_host_streamer_if #(
    parameter int UART_ADDR_W = 3,
    parameter int DATA_W      = 32
);
    logic                   uart_valid;
    logic [UART_ADDR_W-1:0] uart_addr;
    logic [DATA_W-1:0]      uart_wdata;
    logic                   uart_wstrb;
    logic [DATA_W-1:0]      uart_rdata;
    logic                   uart_ready;

    modport master (
        output uart_valid, uart_addr, uart_wdata, uart_wstrb,
        input  uart_rdata, uart_ready
    );

    modport slave (
        input  uart_valid, uart_addr, uart_wdata, uart_wstrb,
        output uart_rdata, uart_ready
    );
endinterface

// File: rtl/uart_host_streamer.sv
// Host side of the firmware-load link: initialises the tester UART, then streams
// upstream bytes into its TX data register, polling TX-ready before every byte.
module uart_host_streamer #(
    parameter int UART_ADDR_W    = 3,
    parameter int DATA_W         = 32,
    parameter int ADDR_SOFTRESET = 0,
    parameter int ADDR_DIV       = 1,
    parameter int ADDR_TXDATA    = 2,
    parameter int ADDR_TXEN      = 3,
    parameter int ADDR_TXREADY   = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] div,
    input  logic [31:0] len,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    output logic        s_ready,
    output logic        busy,
    output logic        done,
    output logic [31:0] sent_cnt,
    uart_host_streamer_if.master uart
);

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_SRST_SET = 4'd1,
        ST_SRST_CLR = 4'd2,
        ST_SET_DIV  = 4'd3,
        ST_TX_EN    = 4'd4,
        ST_GET_BYTE = 4'd5,
        ST_POLL     = 4'd6,
        ST_WRITE    = 4'd7,
        ST_FINISH   = 4'd8
    } state_t;

    state_t                 state_r;
    logic [15:0]            div_r;
    logic [31:0]            len_r;
    logic [7:0]             byte_r;
    logic                   busy_r;
    logic                   done_r;
    logic                   s_ready_r;
    logic [31:0]            sent_cnt_r;
    logic                   valid_r;
    logic [UART_ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0]      wdata_r;
    logic                   wstrb_r;

    // Request the current state would issue, and where it goes once that request completes
    logic [UART_ADDR_W-1:0] req_addr_s;
    logic [DATA_W-1:0]      req_wdata_s;
    logic                   req_wstrb_s;
    state_t                 done_next_s;
    logic                   last_byte_s;
    logic                   rdata_unused_s;

    // Only bit 0 of the status read carries information
    assign rdata_unused_s = ^uart.uart_rdata[DATA_W-1:1];

    // Per-state bus request decode and post-completion successor state
    always_comb begin
        req_addr_s  = UART_ADDR_W'(ADDR_SOFTRESET);
        req_wdata_s = {DATA_W{1'b0}};
        req_wstrb_s = 1'b1;
        done_next_s = ST_IDLE;
        last_byte_s = ((sent_cnt_r + 32'd1) == len_r);
        case (state_r)
            ST_SRST_SET: begin
                req_wdata_s = DATA_W'(1'b1);
                done_next_s = ST_SRST_CLR;
            end
            ST_SRST_CLR: begin
                done_next_s = ST_SET_DIV;
            end
            ST_SET_DIV: begin
                req_addr_s  = UART_ADDR_W'(ADDR_DIV);
                req_wdata_s = DATA_W'(div_r);
                done_next_s = ST_TX_EN;
            end
            ST_TX_EN: begin
                req_addr_s  = UART_ADDR_W'(ADDR_TXEN);
                req_wdata_s = DATA_W'(1'b1);
                done_next_s = (len_r == 32'd0) ? ST_FINISH : ST_GET_BYTE;
            end
            ST_POLL: begin
                req_addr_s  = UART_ADDR_W'(ADDR_TXREADY);
                req_wstrb_s = 1'b0;
                done_next_s = uart.uart_rdata[0] ? ST_WRITE : ST_POLL;
            end
            ST_WRITE: begin
                req_addr_s  = UART_ADDR_W'(ADDR_TXDATA);
                req_wdata_s = {{(DATA_W-8){1'b0}}, byte_r};
                done_next_s = last_byte_s ? ST_FINISH : ST_GET_BYTE;
            end
            default: begin
                done_next_s = ST_IDLE;
            end
        endcase
    end

    // Session FSM; a bus state issues its request in its first (idle-gap) cycle and
    // holds it until uart_ready, so back-to-back requests always have a gap between them
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            div_r      <= 16'd0;
            len_r      <= 32'd0;
            byte_r     <= 8'd0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            s_ready_r  <= 1'b0;
            sent_cnt_r <= 32'd0;
            valid_r    <= 1'b0;
            addr_r     <= {UART_ADDR_W{1'b0}};
            wdata_r    <= {DATA_W{1'b0}};
            wstrb_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        done_r     <= 1'b0;
                        sent_cnt_r <= 32'd0;
                        div_r      <= div;
                        len_r      <= len;
                        busy_r     <= 1'b1;
                        valid_r    <= 1'b1;
                        addr_r     <= UART_ADDR_W'(ADDR_SOFTRESET);
                        wdata_r    <= DATA_W'(1'b1);
                        wstrb_r    <= 1'b1;
                        state_r    <= ST_SRST_SET;
                    end
                end
                ST_SRST_SET, ST_SRST_CLR, ST_SET_DIV, ST_TX_EN, ST_POLL, ST_WRITE: begin
                    if (!valid_r) begin
                        valid_r <= 1'b1;
                        addr_r  <= req_addr_s;
                        wdata_r <= req_wdata_s;
                        wstrb_r <= req_wstrb_s;
                    end else if (uart.uart_ready) begin
                        valid_r <= 1'b0;
                        state_r <= done_next_s;
                        if (done_next_s == ST_GET_BYTE) begin
                            s_ready_r <= 1'b1;
                        end
                        if (state_r == ST_WRITE) begin
                            sent_cnt_r <= sent_cnt_r + 32'd1;
                        end
                    end
                end
                ST_GET_BYTE: begin
                    if (s_valid && s_ready_r) begin
                        byte_r    <= s_data;
                        s_ready_r <= 1'b0;
                        state_r   <= ST_POLL;
                    end
                end
                ST_FINISH: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b1;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_ready         = s_ready_r;
    assign busy            = busy_r;
    assign done            = done_r;
    assign sent_cnt        = sent_cnt_r;
    assign uart.uart_valid = valid_r;
    assign uart.uart_addr  = addr_r;
    assign uart.uart_wdata = wdata_r;
    assign uart.uart_wstrb = wstrb_r;

endmodule

// File: tb/tb_uart_host_streamer.sv
// Scoreboard bench for uart_host_streamer: a bus-slave/source agent plays the UART and
// the byte source, and checks each bus transaction against a queue of expected ones.
module tb_uart_host_streamer;

    localparam logic [2:0] A_SRST  = 3'd0;
    localparam logic [2:0] A_DIV   = 3'd1;
    localparam logic [2:0] A_TXD   = 3'd2;
    localparam logic [2:0] A_TXEN  = 3'd3;
    localparam logic [2:0] A_TXRDY = 3'd4;

    typedef struct packed {
        logic        wstrb;
        logic [2:0]  addr;
        logic [31:0] wdata;
    } txn_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [15:0] div;
    logic [31:0] len;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic        busy;
    logic        done;
    logic [31:0] sent_cnt;

    uart_host_streamer_if #(.UART_ADDR_W(3), .DATA_W(32)) bus ();

    uart_host_streamer #(.UART_ADDR_W(3), .DATA_W(32)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .div      (div),
        .len      (len),
        .s_valid  (s_valid),
        .s_data   (s_data),
        .s_ready  (s_ready),
        .busy     (busy),
        .done     (done),
        .sent_cnt (sent_cnt),
        .uart     (bus)
    );

    int   pass_cnt  = 0;
    int   total_cnt = 0;
    txn_t exp_q[$];
    bit   tr_q[$];
    logic [7:0] src_q[$];
    txn_t snap;
    bit   in_txn, hs_pending, last_done, cnt_chk, prev_s_ready, s_ready_seen;
    int   wait_left, stall_left, exp_sent, wait_mode, stall_mode;

    // Free-running clock
    initial forever #5 clk = ~clk;

    // Hard stop in case something wedges outside the per-session budgets
    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, got running, required finished");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    function automatic txn_t mk(input logic wstrb, input logic [2:0] addr, input logic [31:0] wdata);
        txn_t t;
        t.wstrb = wstrb;
        t.addr  = addr;
        t.wdata = wdata;
        return t;
    endfunction

    // One falling-edge step of the UART slave, byte source and monitors
    task automatic agent_step();
        txn_t        cur;
        txn_t        e;
        logic [31:0] rd;
        cur = mk(bus.uart_wstrb, bus.uart_addr, bus.uart_wdata);
        if (cnt_chk) begin
            check("sent_cnt_step", sent_cnt, exp_sent);
            cnt_chk = 1'b0;
        end
        if (last_done) begin
            check("bus_gap", bus.uart_valid, 1'b0);
            last_done = 1'b0;
        end
        if (prev_s_ready) begin
            if (hs_pending) check("s_ready_drop", s_ready, 1'b0);
            else            check("s_ready_hold", s_ready, 1'b1);
        end
        if (s_ready) begin
            check("no_bus_in_get_byte", bus.uart_valid, 1'b0);
            s_ready_seen = 1'b1;
        end
        // byte source: retire the accepted byte, maybe stall, present the next one
        if (hs_pending) begin
            if (src_q.size() > 0) void'(src_q.pop_front());
            if (stall_mode == 2) stall_left = 14;
            else if (stall_mode == 1 && $urandom_range(0, 2) == 0) stall_left = $urandom_range(1, 12);
            hs_pending = 1'b0;
        end
        if (stall_left > 0) begin
            stall_left--;
            s_valid = 1'b0;
        end else if (src_q.size() > 0) begin
            s_valid = 1'b1;
            s_data  = src_q[0];
        end else begin
            s_valid = 1'b0;
        end
        hs_pending   = s_valid && s_ready;
        prev_s_ready = s_ready;
        // UART slave and transaction scoreboard
        if (bus.uart_valid) begin
            if (!in_txn) begin
                in_txn = 1'b1;
                snap   = cur;
                case (wait_mode)
                    1:       wait_left = 4;
                    2:       wait_left = $urandom_range(0, 5);
                    default: wait_left = 0;
                endcase
            end else begin
                check("req_stable", cur, snap);
            end
            if (wait_left > 0) begin
                wait_left--;
                bus.uart_ready = 1'b0;
                bus.uart_rdata = $urandom;
            end else begin
                in_txn    = 1'b0;
                last_done = 1'b1;
                rd        = $urandom;
                if (!cur.wstrb && cur.addr == A_TXRDY) rd[0] = (tr_q.size() > 0) ? tr_q.pop_front() : 1'b1;
                bus.uart_ready = 1'b1;
                bus.uart_rdata = rd;
                check("txn_expected", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    if (!e.wstrb) cur.wdata = 32'd0;
                    check("txn", cur, e);
                end
                if (cur.wstrb && cur.addr == A_TXD) begin
                    exp_sent++;
                    cnt_chk = 1'b1;
                end
            end
        end else begin
            bus.uart_ready = 1'($urandom_range(0, 1));
            bus.uart_rdata = $urandom;
        end
    endtask

    // Agent process: resets its own state while reset_n is low, otherwise steps once per falling edge
    initial begin
        bus.uart_ready = 1'b0;
        bus.uart_rdata = 32'd0;
        s_valid = 1'b0;
        s_data  = 8'd0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                bus.uart_ready = 1'b0;
                bus.uart_rdata = 32'd0;
                s_valid = 1'b0;
                s_data  = 8'd0;
                in_txn = 1'b0; wait_left = 0; hs_pending = 1'b0; stall_left = 0;
                last_done = 1'b0; cnt_chk = 1'b0; prev_s_ready = 1'b0;
            end else begin
                agent_step();
            end
        end
    end

    task automatic check_outputs_zero(input string name);
        check({name, "_busy"},     busy,           1'b0);
        check({name, "_done"},     done,           1'b0);
        check({name, "_sent_cnt"}, sent_cnt,       32'd0);
        check({name, "_s_ready"},  s_ready,        1'b0);
        check({name, "_valid"},    bus.uart_valid, 1'b0);
        check({name, "_req"},      {bus.uart_wstrb, bus.uart_addr, bus.uart_wdata}, 36'd0);
    endtask

    task automatic quiet_check(input string name, input int n);
        bit seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus.uart_valid) seen = 1'b1;
        end
        check(name, seen, 1'b0);
    endtask

    // Build the expected transaction list for a session, fill the source, pulse start
    task automatic launch(input int dv, input int ln, input int fixed_k, input int max_k, input bit dir_bytes);
        logic [15:0] dv16;
        logic [7:0]  b;
        int          k;
        dv16 = dv[15:0];
        @(negedge clk);
        exp_q.push_back(mk(1'b1, A_SRST, 32'd1));
        exp_q.push_back(mk(1'b1, A_SRST, 32'd0));
        exp_q.push_back(mk(1'b1, A_DIV,  {16'd0, dv16}));
        exp_q.push_back(mk(1'b1, A_TXEN, 32'd1));
        for (int i = 0; i < ln; i++) begin
            b = dir_bytes ? (8'h41 + 8'(i)) : 8'($urandom);
            k = (fixed_k > 0) ? fixed_k : int'($urandom_range(1, max_k));
            for (int j = 0; j < k; j++) begin
                tr_q.push_back(j == k - 1);
                exp_q.push_back(mk(1'b0, A_TXRDY, 32'd0));
            end
            exp_q.push_back(mk(1'b1, A_TXD, {24'd0, b}));
            src_q.push_back(b);
        end
        exp_sent = 0;
        div   = dv16;
        len   = ln;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait for done (bounded) and check the end-of-session state
    task automatic finish_wait(input int ln, input bit timed);
        int cyc = 1;
        while (!done && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        check("done",        done,         1'b1);
        check("busy_end",    busy,         1'b0);
        check("sent_final",  sent_cnt,     ln);
        check("exp_drained", exp_q.size(), 0);
        if (timed) check("latency", cyc, 9 + 5 * ln);
    endtask

    task automatic run_session(input int dv, input int ln, input int fixed_k, input int max_k,
                               input bit dir_bytes, input bit timed);
        launch(dv, ln, fixed_k, max_k, dir_bytes);
        finish_wait(ln, timed);
    endtask

    // Main stimulus sequence
    initial begin
        int cyc;
        reset_n = 1'b1; start = 1'b0; div = 16'd0; len = 32'd0;
        wait_mode = 0; stall_mode = 0; exp_sent = 0; s_ready_seen = 1'b0;
        #3 reset_n = 1'b0;
        #1 check_outputs_zero("reset");
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        quiet_check("idle_quiet", 10);

        // init-only session
        s_ready_seen = 1'b0;
        run_session(434, 0, 1, 1, 1'b0, 1'b1);
        check("init_s_ready_never", s_ready_seen, 1'b0);

        // three directed bytes, zero wait states
        run_session(100, 3, 1, 1, 1'b1, 1'b1);

        // back-pressure: five not-ready polls then ready
        run_session(77, 1, 6, 1, 1'b0, 1'b0);

        // four-cycle wait states on every transaction
        wait_mode = 1;
        run_session(12, 3, 1, 1, 1'b0, 1'b0);
        wait_mode = 0;

        // long source stalls while waiting for each byte
        stall_mode = 2;
        run_session(5, 3, 1, 1, 1'b0, 1'b0);
        stall_mode = 0;

        // random sessions with wait states, stalls and polling
        wait_mode = 2; stall_mode = 1;
        for (int r = 0; r < 6; r++) begin
            run_session(int'($urandom_range(0, 65535)), int'($urandom_range(1, 6)), 0, 4, 1'b0, 1'b0);
        end
        wait_mode = 0; stall_mode = 0;

        // start while busy is ignored, then reset aborts after byte 2
        launch(1000, 4, 1, 1, 1'b0);
        repeat (3) @(negedge clk);
        div = 16'd7; len = 32'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_during", busy, 1'b1);
        cyc = 0;
        while (exp_sent < 2 && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        check("abort_point_reached", exp_sent >= 2, 1'b1);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1 check_outputs_zero("abort");
        exp_q.delete();
        tr_q.delete();
        src_q.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        quiet_check("post_abort_quiet", 10);
        run_session(300, 2, 1, 1, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
